// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. Presents one instruction per cycle to
// the pipeline, holds it across stalls, redirects on taken branches and
// exception flushes, and drains an abandoned bus request after a flush.
//
// Optional feature macro: FETCH_ADEL_CHK_EN. When defined, a misaligned PC
// is not fetched. It is presented as an address-error exception (Exc_AdEL).
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   stall                pipeline did not consume the IF output this cycle
//   flush, flush_pc      exception redirect and its handler target
//   br_flag, br_target   taken branch/jump resolved in ID and its target
//   ibus_req/addr        fetch request and address (held stable until ack)
//   ibus_ack/rdata       request completion and returned word
//   if_pc, if_pcp4       PC of the presented instruction, and PC+4
//   if_inst, if_excp     presented instruction and its fetch exception code
//   if_valid             if_inst/if_excp are valid
//   if_stallreq          fetch is pending, so the pipeline must stall

`ifndef ExcBus
`define ExcBus 4:0
`endif
`ifndef Exc_NoExc
`define Exc_NoExc 5'h00
`endif
`ifndef Exc_AdEL
`define Exc_AdEL 5'h04
`endif

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  input  logic [31:0]    flush_pc,
  input  logic           br_flag,
  input  logic [31:0]    br_target,
  output logic           ibus_req,
  output logic [31:0]    ibus_addr,
  input  logic           ibus_ack,
  input  logic [31:0]    ibus_rdata,
  output logic [31:0]    if_pc,
  output logic [31:0]    if_pcp4,
  output logic [31:0]    if_inst,
  output logic [`ExcBus] if_excp,
  output logic           if_valid,
  output logic           if_stallreq
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_pend_tgt_q, br_pend_tgt_d;
  // Address of the request still outstanding while its data is being dropped
  logic [31:0] old_addr_q, old_addr_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        accept;
  logic        adel;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ADEL_CHK_EN
  assign adel = (pc_q[1:0] != 2'b00);
`else
  assign adel = 1'b0;
`endif

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      inst_buf_q    <= 32'h0;
      br_pend_q     <= 1'b0;
      br_pend_tgt_q <= 32'h0;
      old_addr_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_buf_q    <= inst_buf_d;
      br_pend_q     <= br_pend_d;
      br_pend_tgt_q <= br_pend_tgt_d;
      old_addr_q    <= old_addr_d;
    end
  end

  // Outputs, redirect selection and next state
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_buf_d    = inst_buf_q;
    br_pend_d     = br_pend_q;
    br_pend_tgt_d = br_pend_tgt_q;
    old_addr_d    = old_addr_q;
    ibus_req      = 1'b0;
    ibus_addr     = pc_q;
    if_valid      = 1'b0;
    if_inst       = 32'h0;
    if_excp       = `Exc_NoExc;
    if_stallreq   = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (adel) begin
          if_valid = 1'b1;
          if_excp  = `Exc_AdEL;
        end else begin
          ibus_req    = 1'b1;
          if_valid    = ibus_ack;
          if_inst     = ibus_ack ? ibus_rdata : 32'h0;
          if_stallreq = !ibus_ack;
        end
      end
      S_HOLD: begin
        if_valid = 1'b1;
        if_inst  = inst_buf_q;
      end
      S_DISCARD: begin
        ibus_req    = 1'b1;
        ibus_addr   = old_addr_q;
        if_stallreq = 1'b1;
      end
      default: ;
    endcase

    accept  = if_valid && !stall && !flush;
    next_pc = br_flag ? br_target : (br_pend_q ? br_pend_tgt_q : pc_plus4);

    // A branch resolved while IF is not advancing is remembered until the next accept
    if (flush || accept) begin
      br_pend_d = 1'b0;
    end else if (br_flag) begin
      br_pend_d     = 1'b1;
      br_pend_tgt_d = br_target;
    end

    case (state_q)
      S_FETCH: begin
        if (flush) begin
          pc_d = flush_pc;
          // A request still in flight must complete on its old address
          if (!adel && !ibus_ack) begin
            old_addr_d = pc_q;
            state_d    = S_DISCARD;
          end
        end else if (accept) begin
          pc_d = next_pc;
        end else if (!adel && ibus_ack) begin
          inst_buf_d = ibus_rdata;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_d    = flush_pc;
          state_d = S_FETCH;
        end else if (accept) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (flush) begin
          pc_d = flush_pc;
        end
        if (ibus_ack) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign if_pc   = pc_q;
  assign if_pcp4 = pc_plus4;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios followed by random traffic,
// every cycle checked against a transaction-level model of the fetch stream.

`ifndef ExcBus
`define ExcBus 4:0
`endif
`ifndef Exc_NoExc
`define Exc_NoExc 5'h00
`endif
`ifndef Exc_AdEL
`define Exc_AdEL 5'h04
`endif

module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef FETCH_ADEL_CHK_EN
  localparam bit ADEL_ON = 1'b1;
`else
  localparam bit ADEL_ON = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           stall;
  logic           flush;
  logic [31:0]    flush_pc;
  logic           br_flag;
  logic [31:0]    br_target;
  logic           ibus_req;
  logic [31:0]    ibus_addr;
  logic           ibus_ack;
  logic [31:0]    ibus_rdata;
  logic [31:0]    if_pc;
  logic [31:0]    if_pcp4;
  logic [31:0]    if_inst;
  logic [`ExcBus] if_excp;
  logic           if_valid;
  logic           if_stallreq;

  int n_chk;
  int n_fail;

  // Model of the instruction stream
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_ptgt;
  logic        m_held;
  logic        m_disc;
  logic [31:0] m_old;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .br_flag    (br_flag),
    .br_target  (br_target),
    .ibus_req   (ibus_req),
    .ibus_addr  (ibus_addr),
    .ibus_ack   (ibus_ack),
    .ibus_rdata (ibus_rdata),
    .if_pc      (if_pc),
    .if_pcp4    (if_pcp4),
    .if_inst    (if_inst),
    .if_excp    (if_excp),
    .if_valid   (if_valid),
    .if_stallreq(if_stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word is a unique function of its address
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_pend = 1'b0;
    m_ptgt = 32'h0;
    m_held = 1'b0;
    m_disc = 1'b0;
    m_old  = 32'h0;
  endtask

  // One clock cycle: drive inputs just after the edge, check at negedge,
  // advance the model, return just after the next rising edge.
  task automatic step(input logic s, input logic f, input logic [31:0] fp,
                      input logic b, input logic [31:0] bt, input logic a);
    logic        adel, fetch, ev, ereq, estl, acc, outst;
    logic [31:0] nxt;
    stall      = s;
    flush      = f;
    flush_pc   = fp;
    br_flag    = b;
    br_target  = bt;
    ibus_ack   = a && ibus_req;
    ibus_rdata = ibus_ack ? imem(ibus_addr) : 32'hDEAD_BEEF;
    @(negedge clk);
    fetch = !m_held && !m_disc;
    adel  = ADEL_ON && fetch && (m_pc[1:0] != 2'b00);
    ev    = m_held || (fetch && (adel || ibus_ack));
    ereq  = !m_held && !adel;
    estl  = m_disc || (fetch && !adel && !ibus_ack);
    chk("if_pc", if_pc, m_pc);
    chk("if_pcp4", if_pcp4, m_pc + 32'd4);
    chk("if_valid", 32'(if_valid), 32'(ev));
    chk("ibus_req", 32'(ibus_req), 32'(ereq));
    if (ereq) chk("ibus_addr", ibus_addr, m_disc ? m_old : m_pc);
    chk("if_inst", if_inst, (ev && !adel) ? imem(m_pc) : 32'h0);
    chk("if_excp", 32'(if_excp), adel ? 32'(`Exc_AdEL) : 32'(`Exc_NoExc));
    chk("if_stallreq", 32'(if_stallreq), 32'(estl));
    // Advance the model
    acc   = ev && !s && !f;
    nxt   = b ? bt : (m_pend ? m_ptgt : m_pc + 32'd4);
    outst = fetch && !adel && !ibus_ack;
    if (outst && f) m_old = m_pc;
    m_held = !f && (m_held ? s : (fetch && !adel && ibus_ack && s));
    m_disc = (outst && f) || (m_disc && !ibus_ack);
    if (f) begin
      m_pc   = fp;
      m_pend = 1'b0;
    end else if (acc) begin
      m_pc   = nxt;
      m_pend = 1'b0;
    end else if (b) begin
      m_pend = 1'b1;
      m_ptgt = bt;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    flush_pc  = 32'h0;
    br_flag   = 1'b0;
    br_target = 32'h0;
    ibus_ack  = 1'b0;
    ibus_rdata = 32'h0;
    model_reset();

    // Outputs while reset is held
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(ibus_req), 32'd1);
    chk("rst_addr", ibus_addr, RST_PC);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_stallreq", 32'(if_stallreq), 32'd1);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_excp", 32'(if_excp), 32'(`Exc_NoExc));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back fetch with single-cycle ack
    step(0, 0, 0, 0, 0, 1);
    chk("seq_pc1", if_pc, 32'hBFC0_0004);
    step(0, 0, 0, 0, 0, 1);
    chk("seq_pc2", if_pc, 32'hBFC0_0008);
    step(0, 0, 0, 0, 0, 1);
    chk("seq_pc3", if_pc, 32'hBFC0_000C);

    // Acked word held across a 3-cycle stall
    step(1, 0, 0, 0, 0, 1);
    chk("hold_req", 32'(ibus_req), 32'd0);
    chk("hold_inst", if_inst, imem(32'hBFC0_000C));
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("hold_next_addr", ibus_addr, 32'hBFC0_0010);

    // Branch resolved during a stall is taken after release
    step(1, 0, 0, 1, 32'h8000_0100, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("brpend_pc", if_pc, 32'h8000_0100);

    // Flush with the request outstanding for two cycles
    step(0, 1, 32'h8000_0180, 0, 0, 0);
    chk("disc_addr0", ibus_addr, 32'h8000_0100);
    step(0, 0, 0, 0, 0, 0);
    chk("disc_addr1", ibus_addr, 32'h8000_0100);
    step(0, 0, 0, 0, 0, 1);
    chk("disc_next_addr", ibus_addr, 32'h8000_0180);

    // Flush and branch in the same cycle: flush wins, branch is forgotten
    step(1, 1, 32'h8000_0200, 1, 32'h8000_0300, 1);
    chk("flushbr_pc", if_pc, 32'h8000_0200);
    step(0, 0, 0, 0, 0, 1);
    chk("flushbr_next", if_pc, 32'h8000_0204);

    // PC wraps at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_pcp4", if_pcp4, 32'h0);
    step(0, 0, 0, 0, 0, 1);
    chk("wrap_pc", if_pc, 32'h0);

    // Branch to a misaligned target
    step(0, 0, 0, 1, 32'h8000_0102, 1);
`ifdef FETCH_ADEL_CHK_EN
    chk("adel_req", 32'(ibus_req), 32'd0);
    chk("adel_valid", 32'(if_valid), 32'd1);
    chk("adel_excp", 32'(if_excp), 32'(`Exc_AdEL));
`else
    chk("mis_req", 32'(ibus_req), 32'd1);
    chk("mis_addr", ibus_addr, 32'h8000_0102);
    chk("mis_excp", 32'(if_excp), 32'(`Exc_NoExc));
`endif
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h8000_0400, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic s, f, b, a;
      logic [31:0] fp, bt;
      s  = ($urandom_range(0, 2) == 0);
      f  = ($urandom_range(0, 15) == 0);
      b  = ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 2) != 0);
      r  = $urandom();
      fp = r;
      fp[1:0] = 2'b00;
      r  = $urandom();
      bt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : r;
      bt[1:0] = 2'b00;
      step(s, f, fp, b, bt, a);
    end

    // Asynchronous reset while a request is outstanding
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_pc", if_pc, RST_PC);
    chk("arst_valid", 32'(if_valid), 32'd0);
    model_reset();
    stall   = 1'b0;
    flush   = 1'b0;
    br_flag = 1'b0;
    ibus_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_first_addr", ibus_addr, RST_PC);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
